// File: rtl/ram_pkg.sv
// Shared definitions for the ram_bank slice: clear-sequencer state encoding
// and the byte-lane count helper.
package ram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  localparam int unsigned BYTE_W = 8;

  function automatic int unsigned byte_count(input int unsigned data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/ram_bank_if.sv
// Request/response bundle for ram_bank.
// The parity_err signal exists only when RAM_BANK_PARITY_EN is defined.
interface ram_bank_if
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
);
  localparam int unsigned NB = byte_count(DATA_W);

  logic              clear;
  logic              read;
  logic              write;
  logic [NB-1:0]     byte_en;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              ready_r;
  logic              ready_w;
  logic              busy;
  logic              addr_err;
`ifdef RAM_BANK_PARITY_EN
  logic              parity_err;

  modport master (
    output clear, read, write, byte_en, address, data_in,
    input  data_out, ready_r, ready_w, busy, addr_err, parity_err
  );
  modport slave (
    input  clear, read, write, byte_en, address, data_in,
    output data_out, ready_r, ready_w, busy, addr_err, parity_err
  );
`else
  modport master (
    output clear, read, write, byte_en, address, data_in,
    input  data_out, ready_r, ready_w, busy, addr_err
  );
  modport slave (
    input  clear, read, write, byte_en, address, data_in,
    output data_out, ready_r, ready_w, busy, addr_err
  );
`endif

endinterface

// File: rtl/ram_clear_seq.sv
// Clear sequencer: walks a zero-write pointer over every word, one per cycle,
// starting out of reset and on each clear request seen in IDLE.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned IDX_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  output logic             busy,
  output logic             clr_we,
  output logic [IDX_W-1:0] clr_addr
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  clr_state_e       state_q;
  logic [IDX_W-1:0] ptr_q;
  logic             busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          if (ptr_q == LAST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        default: begin
          state_q <= CLEAR;
          ptr_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign clr_we   = busy_q;
  assign clr_addr = ptr_q;

endmodule

// File: rtl/ram_bank.sv
// Single-port byte-enabled RAM bank with registered read, read-first collisions
// and a self-clearing storage array. Optional per-byte parity: RAM_BANK_PARITY_EN.
module ram_bank
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 128
) (
  input  logic       clk,
  input  logic       reset,
  ram_bank_if.slave  bus
);

  localparam int unsigned   NB      = byte_count(DATA_W);
  localparam int unsigned   IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic             busy;
  logic             clr_we;
  logic [IDX_W-1:0] clr_addr;

  ram_clear_seq #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_clear_seq (
    .clk      (clk),
    .rst_n    (reset),
    .clear    (bus.clear),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic             accept;
  logic             in_range;
  logic             rd_acc;
  logic             wr_acc;
  logic [IDX_W-1:0] idx;

  assign accept   = !busy && !bus.clear;
  assign in_range = ({1'b0, bus.address} < DEPTH_C);
  assign idx      = bus.address[IDX_W-1:0];
  assign rd_acc   = accept && bus.read;
  assign wr_acc   = accept && bus.write && in_range;

  // Storage is deliberately not reset; only the clear sequence zeroes it.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_acc) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (bus.byte_en[b]) mem_q[idx][b*BYTE_W +: BYTE_W] <= bus.data_in[b*BYTE_W +: BYTE_W];
      end
    end
  end

`ifdef RAM_BANK_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] rd_par_bad;
  logic          parity_err_q;
  logic          parity_err_d;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      par_q[clr_addr] <= '0;
    end else if (wr_acc) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (bus.byte_en[b]) par_q[idx][b] <= ^bus.data_in[b*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    rd_par_bad = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      rd_par_bad[b] = (^mem_q[idx][b*BYTE_W +: BYTE_W]) ^ par_q[idx][b];
    end
    parity_err_d = rd_acc && in_range && (|rd_par_bad);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) parity_err_q <= 1'b0;
    else        parity_err_q <= parity_err_d;
  end

  assign bus.parity_err = parity_err_q;
`endif

  logic [DATA_W-1:0] data_out_q;
  logic [DATA_W-1:0] data_out_d;
  logic              ready_r_q;
  logic              ready_w_q;
  logic              addr_err_q;

  // Read-first: the registered read samples mem_q before the same-edge write lands.
  always_comb begin
    data_out_d = data_out_q;
    if (rd_acc) data_out_d = in_range ? mem_q[idx] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_q <= '0;
      ready_r_q  <= 1'b0;
      ready_w_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      ready_r_q  <= rd_acc;
      ready_w_q  <= accept && bus.write;
      addr_err_q <= accept && (bus.read || bus.write) && !in_range;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.ready_r  = ready_r_q;
  assign bus.ready_w  = ready_w_q;
  assign bus.addr_err = addr_err_q;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_ram_bank.sv
// Directed bench for ram_bank (DATA_W=32, ADDR_W=8, DEPTH=128): vector table
// plus hand sequences for reset-time clear and clear/reset interaction.
module tb_ram_bank;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   n;

  ram_bank_if #(.DATA_W(32), .ADDR_W(8)) bus ();

  ram_bank #(
    .DATA_W (32),
    .ADDR_W (8),
    .DEPTH  (128)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [7:0]  addr;
    logic [31:0] din;
    logic        exp_rr;
    logic        exp_rw;
    logic        exp_ae;
    logic [31:0] exp_do;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [3:0] be,
                              input logic [7:0] addr, input logic [31:0] din,
                              input logic rr, input logic rw, input logic ae,
                              input logic [31:0] dout);
    vec_t v;
    v.rd = rd; v.wr = wr; v.be = be; v.addr = addr; v.din = din;
    v.exp_rr = rr; v.exp_rw = rw; v.exp_ae = ae; v.exp_do = dout;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.clear   = 1'b0;
    bus.read    = 1'b0;
    bus.write   = 1'b0;
    bus.byte_en = '0;
    bus.address = '0;
    bus.data_in = '0;
  endtask

  task automatic do_read(input string name, input logic [7:0] addr, input logic [31:0] exp);
    @(negedge clk);
    bus.read    = 1'b1;
    bus.address = addr;
    @(posedge clk);
    #1;
    bus.read = 1'b0;
    check({name, "_ready_r"}, {31'b0, bus.ready_r}, 32'd1);
    check({name, "_data"}, bus.data_out, exp);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    idle_inputs();
    reset = 1'b0;

    #12;
    check("rst_busy",     {31'b0, bus.busy},     32'd1);
    check("rst_data_out", bus.data_out,          32'd0);
    check("rst_ready_r",  {31'b0, bus.ready_r},  32'd0);
    check("rst_ready_w",  {31'b0, bus.ready_w},  32'd0);
    check("rst_addr_err", {31'b0, bus.addr_err}, 32'd0);

    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (bus.busy && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("init_clear_cycles", n, 32'd128);

    // rd wr be addr din | rr rw ae data_out
    vecs.push_back(mk(1, 0, 4'hF, 8'h10, 32'h0,        1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 4'hF, 8'd127, 32'h0,       1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 4'hF, 8'h10, 32'hA5,       0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 0, 4'hF, 8'h10, 32'h0,        1, 0, 0, 32'hA5));
    vecs.push_back(mk(0, 1, 4'hF, 8'd20, 32'h11223344, 0, 1, 0, 32'hA5));
    vecs.push_back(mk(0, 1, 4'h5, 8'd20, 32'hAABBCCDD, 0, 1, 0, 32'hA5));
    vecs.push_back(mk(1, 0, 4'hF, 8'd20, 32'h0,        1, 0, 0, 32'h11BB33DD));
    vecs.push_back(mk(0, 1, 4'hF, 8'd5,  32'h3C,       0, 1, 0, 32'h11BB33DD));
    vecs.push_back(mk(1, 1, 4'hF, 8'd5,  32'h7F,       1, 1, 0, 32'h3C));
    vecs.push_back(mk(1, 0, 4'hF, 8'd5,  32'h0,        1, 0, 0, 32'h7F));
    vecs.push_back(mk(1, 0, 4'hF, 8'd200, 32'h0,       1, 0, 1, 32'h0));
    vecs.push_back(mk(0, 1, 4'hF, 8'd200, 32'hDEADBEEF, 0, 1, 1, 32'h0));
    vecs.push_back(mk(0, 1, 4'h0, 8'h10, 32'hFFFFFFFF, 0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 0, 4'hF, 8'h10, 32'h0,        1, 0, 0, 32'hA5));
    vecs.push_back(mk(1, 0, 4'hF, 8'd72, 32'h0,        1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 4'hF, 8'd127, 32'hCAFEF00D, 0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 0, 4'hF, 8'd127, 32'h0,       1, 0, 0, 32'hCAFEF00D));
    vecs.push_back(mk(1, 0, 4'hF, 8'd128, 32'h0,       1, 0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 4'hF, 8'd127, 32'h0,       1, 0, 0, 32'hCAFEF00D));
    vecs.push_back(mk(0, 0, 4'hF, 8'd127, 32'h0,       0, 0, 0, 32'hCAFEF00D));

    foreach (vecs[i]) begin
      @(negedge clk);
      bus.read    = vecs[i].rd;
      bus.write   = vecs[i].wr;
      bus.byte_en = vecs[i].be;
      bus.address = vecs[i].addr;
      bus.data_in = vecs[i].din;
      @(posedge clk);
      #1;
      idle_inputs();
      check($sformatf("vec%0d_ready_r", i),  {31'b0, bus.ready_r},  {31'b0, vecs[i].exp_rr});
      check($sformatf("vec%0d_ready_w", i),  {31'b0, bus.ready_w},  {31'b0, vecs[i].exp_rw});
      check($sformatf("vec%0d_addr_err", i), {31'b0, bus.addr_err}, {31'b0, vecs[i].exp_ae});
      check($sformatf("vec%0d_data_out", i), bus.data_out,          vecs[i].exp_do);
      check($sformatf("vec%0d_busy", i),     {31'b0, bus.busy},     32'd0);
    end

    // Clear with a same-cycle write: the write must be dropped.
    @(negedge clk);
    bus.clear   = 1'b1;
    bus.write   = 1'b1;
    bus.byte_en = 4'hF;
    bus.address = 8'h10;
    bus.data_in = 32'h55;
    @(posedge clk);
    #1;
    idle_inputs();
    check("clr_wr_ready_w", {31'b0, bus.ready_w}, 32'd0);
    check("clr_busy",       {31'b0, bus.busy},    32'd1);
    check("clr_data_hold",  bus.data_out,         32'hCAFEF00D);

    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      bus.read    = (i == 10);
      bus.address = 8'h10;
      @(posedge clk);
      #1;
      if (i == 10) check("clr_rd_dropped", {31'b0, bus.ready_r}, 32'd0);
      bus.read = 1'b0;
    end

    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midclr_rst_busy",     {31'b0, bus.busy}, 32'd1);
    check("midclr_rst_data_out", bus.data_out,      32'd0);

    @(negedge clk);
    reset       = 1'b1;
    bus.clear   = 1'b1;
    bus.read    = 1'b1;
    bus.address = 8'h10;
    n = 0;
    while (bus.busy && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (n <= 5) check("restart_rd_dropped", {31'b0, bus.ready_r}, 32'd0);
      if (n == 5) begin
        bus.clear = 1'b0;
        bus.read  = 1'b0;
      end
    end
    check("restart_clear_cycles", n, 32'd128);

    do_read("post_clr_rd10",  8'h10,  32'h0);
    do_read("post_clr_rd127", 8'd127, 32'h0);
    do_read("post_clr_rd5",   8'd5,   32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_bank.md
RAM_BANK -- requirements
Module: ram_bank

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data word width in bits, a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 128, meaning the number of words, 1 <= DEPTH <= 2^ADDR_W.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port clear, input, 1 bit: request a full memory clear.
REQ-007 The block SHALL have ports read and write, input, 1 bit each: access requests.
REQ-008 The block SHALL have port byte_en, input, DATA_W/8 bits: per-byte write enable.
REQ-009 The block SHALL have port address, input, ADDR_W bits: word address.
REQ-010 The block SHALL have port data_in, input, DATA_W bits: write data.
REQ-011 The block SHALL have port data_out, output, DATA_W bits: registered read data.
REQ-012 The block SHALL have ports ready_r and ready_w, output, 1 bit each: completion pulses.
REQ-013 The block SHALL have port busy, output, 1 bit: clear sequence in progress, so accesses are refused.
REQ-014 The block SHALL have port addr_err, output, 1 bit: single-cycle pulse for an out-of-range access.

Function
REQ-015 The block SHALL implement FSM states IDLE and CLEAR; busy = 1 exactly while in CLEAR.
- CLEAR writes zero to one word per cycle at pointer 0..DEPTH-1.
- After writing word DEPTH-1, it moves to IDLE.
REQ-016 The block SHALL accept read/write only in IDLE with clear low; requests in CLEAR, or in the cycle clear is sampled, are dropped with no pulse.
REQ-017 The block SHALL, when clear is high in IDLE, enter CLEAR next cycle with pointer 0; clear asserted while already in CLEAR is ignored.
REQ-018 The block SHALL, for an accepted write, update only the bytes whose byte_en bit is 1, and pulse ready_w for one cycle on the next edge.
REQ-019 The block SHALL, for an accepted read, load data_out and pulse ready_r for one cycle on the next edge (latency 1); data_out holds until the next accepted read.
REQ-020 The block SHALL, on simultaneous read and write to the same address, be read-first: data_out returns the pre-write word, and both ready_r and ready_w pulse.
REQ-021 The block SHALL, for address >= DEPTH, ignore the write, load data_out with zero, still pulse ready_r/ready_w, and pulse addr_err in the same cycle.
REQ-022 The block SHALL treat byte_en = 0 with write as a legal write: ready_w pulses and memory is unchanged.

Reset
REQ-023 The block SHALL, on reset low, asynchronously force data_out = 0, ready_r = 0, ready_w = 0, addr_err = 0, busy = 1, state = CLEAR, pointer = 0.
REQ-024 The block SHALL, after reset is released, run a full clear of DEPTH cycles before the first access is accepted.
REQ-025 The block SHALL, on reset asserted mid-clear or mid-access, abandon that operation and restart the clear from pointer 0.
REQ-026 The block SHALL NOT asynchronously reset the storage array; it is zeroed only by the CLEAR sequence.

Configuration
REQ-027 The block SHALL support macro RAM_BANK_PARITY_EN.
- Defined: one even-parity bit per byte is stored; output parity_err (1 bit) is added, pulsing with ready_r when any read byte mismatches; CLEAR writes parity 0; parity_err resets to 0.
- Undefined: no parity storage and no parity_err port.

Structure
REQ-028 The block SHALL take its FSM state encoding (IDLE, CLEAR) and the byte-count helper constant from shared package ram_pkg.
REQ-029 The block SHALL implement the clear pointer/FSM as sub-module ram_clear_seq, with outputs busy, clr_we and clr_addr.

Verification
REQ-030 The bench SHALL check: release reset with DEPTH=128 -> busy high for exactly 128 cycles, then low; a read of any address returns 0.
REQ-031 The bench SHALL check: write 0xA5 to address 0x10, then read 0x10 -> ready_w pulses, then ready_r pulses one cycle after the read with data_out = 0xA5.
REQ-032 The bench SHALL check, with DATA_W=32: word 0x11223344, write 0xAABBCCDD with byte_en=0b0101 -> read returns 0x11BB33DD.
REQ-033 The bench SHALL check: read and write of 0x7F to address 5 (old value 0x3C) in the same cycle -> data_out = 0x3C; a following read returns 0x7F.
REQ-034 The bench SHALL check: read of address 200 with DEPTH=128 -> data_out = 0, ready_r and addr_err pulse together; a write to 200 leaves the memory unchanged.
REQ-035 The bench SHALL check: clear at cycle 0 with write requested in the same cycle, then reset pulsed at clear cycle 60 -> write dropped, busy stays high, and the clear restarts and completes 128 cycles after reset release.
